// File: rtl/gcd_stream_pkg.sv
// Shared definitions for the streaming GCD engine: FSM states and algorithm selects.
package gcd_stream_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_EUCLID = 1'b0;
   localparam logic MODE_STEIN  = 1'b1;

endpackage

// File: rtl/gcd_step.sv
// One GCD iteration: decides termination and result, otherwise produces the next (A, B, k).
module gcd_step
   import gcd_stream_pkg::*;
#(
   parameter int WIDTH = 7,
   parameter int K_W   = 3
)
(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [K_W-1:0]   k,
   input  logic             mode,
   output logic [WIDTH-1:0] a_next,
   output logic [WIDTH-1:0] b_next,
   output logic [K_W-1:0]   k_next,
   output logic             finish,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   // Termination checks take priority over any reduction step; the common
   // power-of-two factor removed by Stein is restored through k.
   always_comb begin
      a_next = a;
      b_next = b;
      k_next = k;
      finish = 1'b0;
      result = '0;
      zero   = 1'b0;
      if (a == '0 || b == '0) begin
         finish = 1'b1;
         result = (a | b) << k;
         zero   = (a == '0) && (b == '0);
      end else if (a == b) begin
         finish = 1'b1;
         result = a << k;
      end else if (mode == MODE_EUCLID) begin
         if (a > b) a_next = a - b;
         else       b_next = b - a;
      end else begin
         if (!a[0] && !b[0]) begin
            a_next = a >> 1;
            b_next = b >> 1;
            k_next = k + K_W'(1);
         end else if (!a[0]) begin
            a_next = a >> 1;
         end else if (!b[0]) begin
            b_next = b >> 1;
         end else if (a > b) begin
            a_next = a - b;
         end else begin
            b_next = b - a;
         end
      end
   end

endmodule

// File: rtl/gcd_stream.sv
// Iterative GCD engine with valid/ready on both sides, selectable Euclid or Stein per request.
module gcd_stream
   import gcd_stream_pkg::*;
#(
   parameter int WIDTH = 7,
   parameter int CNT_W = 8
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             mode_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] gcd_out,
   output logic [CNT_W-1:0] cycles_out,
   output logic             zero_flag
);

   localparam int K_W = $clog2(WIDTH + 1);

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [K_W-1:0]   k;
   logic             mode;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;

   logic [WIDTH-1:0] a_next;
   logic [WIDTH-1:0] b_next;
   logic [K_W-1:0]   k_next;
   logic             finish;
   logic [WIDTH-1:0] result;
   logic             zero;

   gcd_step #(
      .WIDTH (WIDTH),
      .K_W   (K_W)
   ) u_step (
      .a      (a_reg),
      .b      (b_reg),
      .k      (k),
      .mode   (mode),
      .a_next (a_next),
      .b_next (b_next),
      .k_next (k_next),
      .finish (finish),
      .result (result),
      .zero   (zero)
   );

   // Iteration counter sticks at all-ones rather than wrapping.
   assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) next_state = CALC;
         end
         CALC: begin
            if (finish) next_state = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Result registers load only when CALC terminates, so they hold through DONE and IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         a_reg      <= '0;
         b_reg      <= '0;
         k          <= '0;
         mode       <= MODE_EUCLID;
         cnt        <= '0;
         gcd_out    <= '0;
         cycles_out <= '0;
         zero_flag  <= 1'b0;
      end else begin
         state <= next_state;
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg <= a_in;
                  b_reg <= b_in;
                  mode  <= mode_in;
                  k     <= '0;
                  cnt   <= '0;
               end
            end
            CALC: begin
               cnt   <= cnt_inc;
               a_reg <= a_next;
               b_reg <= b_next;
               k     <= k_next;
               if (finish) begin
                  gcd_out    <= result;
                  cycles_out <= cnt_inc;
                  zero_flag  <= zero;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_stream.sv
// Directed self-checking bench for gcd_stream with hand-computed vectors and a sweep model.
module tb_gcd_stream;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [6:0] a_in;
   logic [6:0] b_in;
   logic       mode_in;
   logic       out_valid;
   logic       out_ready;
   logic [6:0] gcd_out;
   logic [7:0] cycles_out;
   logic       zero_flag;

   int errors = 0;
   int checks = 0;

   gcd_stream #(
      .WIDTH (7),
      .CNT_W (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a_in       (a_in),
      .b_in       (b_in),
      .mode_in    (mode_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .gcd_out    (gcd_out),
      .cycles_out (cycles_out),
      .zero_flag  (zero_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int refGcd(input int a, input int b);
      int x = a;
      int y = b;
      int t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   function automatic int refSubCount(input int a, input int b);
      int x = a;
      int y = b;
      int n = 0;
      while (x != 0 && y != 0 && x != y) begin
         if (x > y) x = x - y;
         else       y = y - x;
         n++;
      end
      return n;
   endfunction

   task automatic sendOp(input int a, input int b, input logic m);
      int waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) checkOutput("in_ready timeout", 0, 1);
      in_valid = 1'b1;
      a_in     = 7'(a);
      b_in     = 7'(b);
      mode_in  = m;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic waitResult(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1 lat++;
      end while (!out_valid && lat < 300);
      if (!out_valid) checkOutput("out_valid timeout", 0, 1);
   endtask

   task automatic takeResult();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic applyStimulus(input string tag, input int a, input int b, input logic m,
                                input int exp_gcd, input int exp_cyc, input int exp_zero);
      int lat;
      sendOp(a, b, m);
      waitResult(lat);
      checkOutput({tag, " gcd"}, int'(gcd_out), exp_gcd);
      checkOutput({tag, " zero"}, int'(zero_flag), exp_zero);
      if (exp_cyc >= 0) begin
         checkOutput({tag, " cycles"}, int'(cycles_out), exp_cyc);
         checkOutput({tag, " latency"}, lat, exp_cyc);
      end
      takeResult();
   endtask

   initial begin
      int lat;
      logic [6:0] held_gcd;
      logic [7:0] held_cyc;

      rst       = 1'b1;
      in_valid  = 1'b0;
      a_in      = '0;
      b_in      = '0;
      mode_in   = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset in_ready", int'(in_ready), 1);
      checkOutput("reset out_valid", int'(out_valid), 0);
      checkOutput("reset gcd", int'(gcd_out), 0);
      checkOutput("reset cycles", int'(cycles_out), 0);
      checkOutput("reset zero", int'(zero_flag), 0);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus("12_18 m0", 12, 18, 1'b0, 6, 3, 0);
      applyStimulus("12_18 m1", 12, 18, 1'b1, 6, 5, 0);
      applyStimulus("15_1 m0", 15, 1, 1'b0, 1, 15, 0);
      applyStimulus("127_127 m0", 127, 127, 1'b0, 127, 1, 0);
      applyStimulus("127_127 m1", 127, 127, 1'b1, 127, 1, 0);
      applyStimulus("0_9 m0", 0, 9, 1'b0, 9, 1, 0);
      applyStimulus("0_9 m1", 0, 9, 1'b1, 9, 1, 0);
      applyStimulus("0_0 m0", 0, 0, 1'b0, 0, 1, 1);
      applyStimulus("96_64 m1", 96, 64, 1'b1, 32, -1, 0);

      // Backpressure: result must hold in DONE and a new request must be ignored.
      sendOp(20, 8, 1'b0);
      waitResult(lat);
      checkOutput("hold gcd", int'(gcd_out), 4);
      held_gcd = gcd_out;
      held_cyc = cycles_out;
      @(negedge clk);
      in_valid = 1'b1;
      a_in     = 7'd9;
      b_in     = 7'd6;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         checkOutput("hold out_valid", int'(out_valid), 1);
         checkOutput("hold in_ready", int'(in_ready), 0);
         checkOutput("hold gcd stable", int'(gcd_out), int'(held_gcd));
         checkOutput("hold cycles stable", int'(cycles_out), int'(held_cyc));
      end
      @(negedge clk);
      in_valid = 1'b0;
      takeResult();
      checkOutput("release in_ready", int'(in_ready), 1);
      checkOutput("release out_valid", int'(out_valid), 0);
      checkOutput("idle keeps gcd", int'(gcd_out), 4);
      repeat (3) @(posedge clk);
      #1 checkOutput("ignored request", int'(in_ready), 1);

      // Reset during the fifth CALC cycle discards the computation.
      sendOp(15, 1, 1'b0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midcalc rst in_ready", int'(in_ready), 1);
      checkOutput("midcalc rst out_valid", int'(out_valid), 0);
      checkOutput("midcalc rst gcd", int'(gcd_out), 0);
      checkOutput("midcalc rst cycles", int'(cycles_out), 0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus("8_12 after rst", 8, 12, 1'b0, 4, 3, 0);

      for (int m = 0; m < 2; m++) begin
         for (int i = 1; i <= 15; i++) begin
            for (int j = 1; j <= 15; j++) begin
               applyStimulus($sformatf("sweep m%0d %0d_%0d", m, i, j), i, j, m[0],
                             refGcd(i, j), (m == 0) ? refSubCount(i, j) + 1 : -1, 0);
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
